ddr_sim_mem: RTL and testbench
==============================

DDR_SIM_MEM -- requirements
Module: ddr_sim_mem

Interface
REQ-001 Parameter DATA_W, 128, user data width in bits (multiple of 8).
REQ-002 Parameter MEM_WORDS, 65536, modelled depth in DATA_W words (power of 2).
REQ-003 Parameter RD_LATENCY, 3, cycles from a read reaching queue head to rd_valid (>=1).
REQ-004 Parameter RQ_DEPTH, 16, read address queue entries (power of 2).
REQ-005 Parameter WR_ACK_DELAY, 8, cycles from accepted write to wr_ack pulse (>=1).
REQ-006 clk  input  1  clock; all logic on rising edge.
REQ-007 reset_n  input  1  reset, synchronous, active-low.
REQ-008 rd_addr_en  input  1  read request strobe.
REQ-009 rd_addr  input  32  read word address.
REQ-010 rd_busy  output  1  read queue full; request not accepted.
REQ-011 rd_data  output  DATA_W  read data, held while rd_valid.
REQ-012 rd_valid  output  1  rd_data valid.
REQ-013 rd_en  input  1  consumer accepts rd_data.
REQ-014 wr_en  input  1  write strobe.
REQ-015 wr_addr  input  32  write word address.
REQ-016 wr_data  input  DATA_W  write data.
REQ-017 wr_datamask  input  DATA_W/8  byte mask, 1 = byte not written.
REQ-018 wr_ack  output  1  single-cycle write acknowledge.
REQ-019 wr_busy  output  1  constant 0.
REQ-020 cal_done, cal_pass  output  1 each  calibration status.
REQ-021 rq_level  output  $clog2(RQ_DEPTH)+1  read queue occupancy.

Function
REQ-022 Memory index SHALL be address modulo MEM_WORDS (low log2(MEM_WORDS) bits); upper bits ignored.
REQ-023 Read request accepted iff rd_addr_en & ~rd_busy; address pushed to FIFO queue in order.
REQ-024 rd_busy SHALL equal (rq_level == RQ_DEPTH) from registered count; a pop in the same cycle does not admit a push when full.
REQ-025 Simultaneous accepted push and pop SHALL leave rq_level unchanged.
REQ-026 Read FSM states IDLE, WAIT, VALID; IDLE->WAIT when queue non-empty, loading latency counter with RD_LATENCY-1.
REQ-027 WAIT decrements counter; at 0 captures mem[head index] into rd_data, sets rd_valid, ->VALID.
REQ-028 VALID holds rd_data and rd_valid stable until rd_en; on rd_valid & rd_en pops head, clears rd_valid, ->IDLE.
REQ-029 rd_en without rd_valid SHALL have no effect.
REQ-030 Write accepted iff wr_en; memory updated at that edge.
REQ-031 Read capture and write to same index on same edge SHALL return old contents.
REQ-032 wr_ack SHALL pulse exactly WR_ACK_DELAY cycles after each accepted write; back-to-back writes give back-to-back acks.
REQ-033 cal_done and cal_pass SHALL be 0 during reset and 1 from the first cycle after reset release.

Reset
REQ-034 Reset SHALL clear rd_valid, rd_data, wr_ack, ack pipeline, queue pointers, rq_level, cal outputs; FSM to IDLE.
REQ-035 Reset mid-read or with acks in flight SHALL drop all pending reads and acks; memory contents retained.

Configuration
REQ-036 Macro DDR_SIM_WR_MASK_EN defined: bytes with wr_datamask bit 1 SHALL keep prior value; others written.
REQ-037 Macro DDR_SIM_WR_MASK_EN undefined: wr_datamask ignored, full word written.

Verification
REQ-038 Write 0x11..11 to addr 5, read addr 5 -> rd_valid 3 cycles after head, rd_data 0x11..11; wr_ack 8 cycles after write.
REQ-039 Push 16 reads with rd_en=0 -> rq_level 16, rd_busy 1, 17th request dropped; rd_data held stable.
REQ-040 Pop and push same cycle at rq_level 5 -> rq_level stays 5, FIFO order preserved.
REQ-041 With DDR_SIM_WR_MASK_EN: word 0 all 0xFF, write zeros mask 0x00FF -> bytes 0-7 0xFF, bytes 8-15 0x00.
REQ-042 Write addr 0x10000 then read addr 0 (MEM_WORDS 65536) -> written data returned (wrap).
REQ-043 Reset asserted in WAIT with 3 queued reads -> rd_valid 0, rq_level 0, no rd_valid after release.

Source files
------------

// File: rtl/ddr_sim_mem.sv
// ddr_sim_mem: behavioural DDR user-interface memory model.
//
// Reads are queued in an address FIFO and served one at a time by a small
// FSM. The FSM leaves IDLE when the queue holds an entry and waits
// RD_LATENCY cycles. It then captures the head word into rd_data and holds it
// (rd_valid high) until the consumer takes it with rd_en. The head entry is
// popped only on that handshake, so rq_level counts every outstanding read,
// including the one on display.
//
// Writes are accepted every cycle that wr_en is high. Each write is
// acknowledged with a one-cycle wr_ack pulse WR_ACK_DELAY cycles later.
// Calibration reports done/pass from the first cycle after reset release.
//
// Optional feature: define DDR_SIM_WR_MASK_EN to honour wr_datamask. A mask
// bit of 1 keeps the old byte. When the macro is undefined, the mask is
// ignored and the full word is written.
//
// Reset is synchronous and active-low. It clears all control state and drops
// pending reads and acks. The memory array keeps its contents.

module ddr_sim_mem #(
   parameter int DATA_W       = 128,
   parameter int MEM_WORDS    = 65536,
   parameter int RD_LATENCY   = 3,
   parameter int RQ_DEPTH     = 16,
   parameter int WR_ACK_DELAY = 8
) (
   input  logic                          clk,
   input  logic                          reset_n,
   // read request side
   input  logic                          rd_addr_en,
   input  logic [31:0]                   rd_addr,
   output logic                          rd_busy,
   // read data side
   output logic [DATA_W-1:0]             rd_data,
   output logic                          rd_valid,
   input  logic                          rd_en,
   // write side
   input  logic                          wr_en,
   input  logic [31:0]                   wr_addr,
   input  logic [DATA_W-1:0]             wr_data,
   input  logic [DATA_W/8-1:0]           wr_datamask,
   output logic                          wr_ack,
   output logic                          wr_busy,
   // status
   output logic                          cal_done,
   output logic                          cal_pass,
   output logic [$clog2(RQ_DEPTH):0]     rq_level
);

   localparam int IDX_W  = $clog2(MEM_WORDS);
   localparam int PTR_W  = $clog2(RQ_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int LAT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
   localparam int MASK_W = DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      VALID
   } rd_state_t;

   // Backing store and read address queue storage.
   logic [DATA_W-1:0] mem    [MEM_WORDS];
   logic [IDX_W-1:0]  rq_mem [RQ_DEPTH];

   logic [PTR_W-1:0]  rq_wr_ptr;
   logic [PTR_W-1:0]  rq_rd_ptr;
   logic [CNT_W-1:0]  rq_count;
   logic              rq_push;
   logic              rq_pop;

   rd_state_t         rd_state;
   logic [LAT_W-1:0]  lat_cnt;

   logic [WR_ACK_DELAY-1:0] ack_pipe;
   logic                    cal_q;

   logic [IDX_W-1:0]  wr_idx;

   // Only the low IDX_W address bits select a word. The upper bits are
   // deliberately ignored, so the address wraps modulo MEM_WORDS.
   assign wr_idx = wr_addr[IDX_W-1:0];

   // Busy comes from the registered count alone. A pop in the same cycle
   // therefore never lets a push into a full queue.
   assign rd_busy  = (rq_count == CNT_W'(RQ_DEPTH));
   assign rq_push  = rd_addr_en & ~rd_busy;
   assign rq_pop   = rd_valid & rd_en;
   assign rq_level = rq_count;

   assign wr_busy  = 1'b0;
   assign wr_ack   = ack_pipe[WR_ACK_DELAY-1];
   assign cal_done = cal_q;
   assign cal_pass = cal_q;

   // Inputs that intentionally have no effect are reduced here.
`ifdef DDR_SIM_WR_MASK_EN
   logic unused_inputs;
   assign unused_inputs = ^{rd_addr[31:IDX_W], wr_addr[31:IDX_W]};
`else
   logic unused_inputs;
   assign unused_inputs = ^{rd_addr[31:IDX_W], wr_addr[31:IDX_W], wr_datamask};
`endif

   // Queue entry storage: holds only the word index of each accepted read.
   // NOTE: storage arrays have no reset. Their contents matter only where the
   // pointers/count say so, and the memory must survive reset anyway.
   always_ff @(posedge clk) begin
      if (rq_push) begin
         rq_mem[rq_wr_ptr] <= rd_addr[IDX_W-1:0];
      end
   end

   // Queue pointers and occupancy. A push and a pop in the same cycle cancel
   // out in the count.
   // NOTE: all sequential state uses non-blocking assignments, so every
   // block sees pre-edge values regardless of evaluation order.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rq_wr_ptr <= '0;
         rq_rd_ptr <= '0;
         rq_count  <= '0;
      end else begin
         if (rq_push) begin
            rq_wr_ptr <= rq_wr_ptr + PTR_W'(1);
         end
         if (rq_pop) begin
            rq_rd_ptr <= rq_rd_ptr + PTR_W'(1);
         end
         case ({rq_push, rq_pop})
            2'b10:   rq_count <= rq_count + CNT_W'(1);
            2'b01:   rq_count <= rq_count - CNT_W'(1);
            default: rq_count <= rq_count;
         endcase
      end
   end

   // Read FSM: wait out the latency for the head entry, then present and hold
   // its data until the consumer accepts it.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_state <= IDLE;
         lat_cnt  <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         case (rd_state)
            IDLE: begin
               if (rq_count != '0) begin
                  lat_cnt  <= LAT_W'(RD_LATENCY - 1);
                  rd_state <= WAIT;
               end
            end
            WAIT: begin
               if (lat_cnt == '0) begin
                  // A write to this index on the same edge is not visible
                  // yet, so the old contents are captured.
                  rd_data  <= mem[rq_mem[rq_rd_ptr]];
                  rd_valid <= 1'b1;
                  rd_state <= VALID;
               end else begin
                  lat_cnt <= lat_cnt - LAT_W'(1);
               end
            end
            VALID: begin
               if (rd_en) begin
                  rd_valid <= 1'b0;
                  rd_state <= IDLE;
               end
            end
            default: begin
               rd_valid <= 1'b0;
               rd_state <= IDLE;
            end
         endcase
      end
   end

   // Memory write port: full-word write, or a byte-merged write when masking
   // is built in.
   always_ff @(posedge clk) begin
      if (wr_en) begin
`ifdef DDR_SIM_WR_MASK_EN
         for (int b = 0; b < MASK_W; b++) begin
            if (!wr_datamask[b]) begin
               mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
         end
`else
         mem[wr_idx] <= wr_data;
`endif
      end
   end

   // Write acknowledge delay line. Every accepted write enters a pulse that
   // appears on wr_ack WR_ACK_DELAY cycles later, so back-to-back writes give
   // back-to-back acks.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ack_pipe <= '0;
      end else begin
         ack_pipe[0] <= wr_en;
         for (int i = 1; i < WR_ACK_DELAY; i++) begin
            ack_pipe[i] <= ack_pipe[i-1];
         end
      end
   end

   // Calibration status: the model is "calibrated" immediately after reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cal_q <= 1'b0;
      end else begin
         cal_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ddr_sim_mem.sv
// Testbench for ddr_sim_mem with directed vectors and hand-computed
// expectations.
//
// Timing used below: inputs change 1 ns after a rising edge, and outputs are
// sampled at the same point. If a read is pushed on edge E0, the FSM leaves
// IDLE on E1 and rd_valid rises on E1+RD_LATENCY = E4. If a write is
// accepted on edge E0, wr_ack is high in the eighth cycle after the write
// cycle, i.e. after edge E7.

module tb_ddr_sim_mem;

   localparam int DATA_W = 128;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              rd_addr_en;
   logic [31:0]       rd_addr;
   logic              rd_busy;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              rd_en;
   logic              wr_en;
   logic [31:0]       wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [15:0]       wr_datamask;
   logic              wr_ack;
   logic              wr_busy;
   logic              cal_done;
   logic              cal_pass;
   logic [4:0]        rq_level;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   ddr_sim_mem dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .rd_addr_en  (rd_addr_en),
      .rd_addr     (rd_addr),
      .rd_busy     (rd_busy),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .rd_en       (rd_en),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_datamask (wr_datamask),
      .wr_ack      (wr_ack),
      .wr_busy     (wr_busy),
      .cal_done    (cal_done),
      .cal_pass    (cal_pass),
      .rq_level    (rq_level)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] pat(input int i);
      logic [31:0] w;
      w = 32'hA500_0000 + 32'(i);
      return {4{w}};
   endfunction

   task automatic wr(input logic [31:0] a, input logic [127:0] d, input logic [15:0] m);
      wr_en       = 1'b1;
      wr_addr     = a;
      wr_data     = d;
      wr_datamask = m;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic push(input logic [31:0] a);
      rd_addr_en = 1'b1;
      rd_addr    = a;
      tick();
      rd_addr_en = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      while (!rd_valid && n < 40) begin
         tick();
         n++;
      end
      check({tag, "_valid"}, 128'(rd_valid), 128'd1);
   endtask

   task automatic pop_check(input string tag, input logic [127:0] exp);
      wait_valid(tag);
      check(tag, rd_data, exp);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   initial begin
      int n;
      logic [11:0] ack_vec;
      int seen;

      reset_n     = 1'b0;
      rd_addr_en  = 1'b0;
      rd_addr     = '0;
      rd_en       = 1'b0;
      wr_en       = 1'b0;
      wr_addr     = '0;
      wr_data     = '0;
      wr_datamask = '0;

      // ---- reset state
      repeat (3) tick();
      check("rst_rd_valid", 128'(rd_valid), 128'd0);
      check("rst_rd_data",  rd_data,        128'd0);
      check("rst_rq_level", 128'(rq_level), 128'd0);
      check("rst_rd_busy",  128'(rd_busy),  128'd0);
      check("rst_wr_ack",   128'(wr_ack),   128'd0);
      check("rst_wr_busy",  128'(wr_busy),  128'd0);
      check("rst_cal_done", 128'(cal_done), 128'd0);
      check("rst_cal_pass", 128'(cal_pass), 128'd0);

      // ---- calibration after release
      reset_n = 1'b1;
      tick();
      check("cal_done", 128'(cal_done), 128'd1);
      check("cal_pass", 128'(cal_pass), 128'd1);

      // ---- write addr 5, ack timing
      wr(32'd5, {16{8'h11}}, 16'h0000);
      n = 0;
      while (!wr_ack && n < 20) begin
         tick();
         n++;
      end
      check("ack_delay", 128'(n), 128'd7);
      tick();
      check("ack_single", 128'(wr_ack), 128'd0);

      // ---- read addr 5, latency and data
      push(32'd5);
      check("rd_level1", 128'(rq_level), 128'd1);
      n = 0;
      while (!rd_valid && n < 20) begin
         tick();
         n++;
      end
      check("rd_latency", 128'(n), 128'd4);
      check("rd_data5", rd_data, {16{8'h11}});
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("pop_valid", 128'(rd_valid), 128'd0);
      check("pop_level", 128'(rq_level), 128'd0);

      // ---- rd_en with nothing valid does nothing
      rd_en = 1'b1;
      repeat (2) tick();
      rd_en = 1'b0;
      check("idle_rden_level", 128'(rq_level), 128'd0);
      check("idle_rden_valid", 128'(rd_valid), 128'd0);

      // ---- four back-to-back writes give four back-to-back acks
      repeat (10) tick();
      for (int i = 0; i < 4; i++) begin
         wr_en       = 1'b1;
         wr_addr     = 32'h200 + 32'(i);
         wr_data     = pat(500 + i);
         wr_datamask = '0;
         tick();
      end
      wr_en = 1'b0;
      for (int j = 0; j < 12; j++) begin
         tick();
         ack_vec[j] = wr_ack;
      end
      check("ack_burst", 128'(ack_vec), 128'h078);

      // ---- fill the read queue: 16 accepted, the 17th dropped
      for (int i = 0; i < 17; i++) begin
         wr_en       = 1'b1;
         wr_addr     = 32'h100 + 32'(i);
         wr_data     = pat(i);
         wr_datamask = '0;
         tick();
      end
      wr_en = 1'b0;
      for (int i = 0; i < 17; i++) begin
         rd_addr_en = 1'b1;
         rd_addr    = 32'h100 + 32'(i);
         tick();
      end
      rd_addr_en = 1'b0;
      check("full_level", 128'(rq_level), 128'd16);
      check("full_busy",  128'(rd_busy),  128'd1);
      check("full_head",  rd_data,        pat(0));
      repeat (5) tick();
      check("hold_valid", 128'(rd_valid), 128'd1);
      check("hold_data",  rd_data,        pat(0));
      check("hold_level", 128'(rq_level), 128'd16);
      for (int i = 0; i < 16; i++) begin
         pop_check($sformatf("drain%0d", i), pat(i));
      end
      repeat (8) tick();
      check("drop17_valid", 128'(rd_valid), 128'd0);
      check("drop17_level", 128'(rq_level), 128'd0);

      // ---- push and pop in the same cycle at level 5
      for (int i = 0; i < 5; i++) begin
         push(32'h100 + 32'(i));
      end
      wait_valid("lvl5");
      check("lvl5_before", 128'(rq_level), 128'd5);
      rd_en      = 1'b1;
      rd_addr_en = 1'b1;
      rd_addr    = 32'h105;
      tick();
      rd_en      = 1'b0;
      rd_addr_en = 1'b0;
      check("lvl5_after", 128'(rq_level), 128'd5);
      for (int i = 1; i <= 5; i++) begin
         pop_check($sformatf("order%0d", i), pat(i));
      end
      check("order_empty", 128'(rq_level), 128'd0);

      // ---- capture and write to the same word on the same edge
      wr(32'h300, pat(100), 16'h0000);
      push(32'h300);
      repeat (3) tick();
      wr(32'h300, pat(200), 16'h0000);
      check("raw_valid", 128'(rd_valid), 128'd1);
      check("raw_old",   rd_data,        pat(100));
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      push(32'h300);
      pop_check("raw_new", pat(200));

      // ---- byte mask (merged only when the mask feature is built in)
      wr(32'd0, {16{8'hFF}}, 16'h0000);
      wr(32'd0, 128'd0,      16'h00FF);
      push(32'd0);
`ifdef DDR_SIM_WR_MASK_EN
      pop_check("mask_merge", {64'h0, 64'hFFFF_FFFF_FFFF_FFFF});
`else
      pop_check("mask_ignored", 128'd0);
`endif

      // ---- address wrap modulo MEM_WORDS
      wr(32'h0001_0000, pat(300), 16'h0000);
      push(32'd0);
      pop_check("wrap_wr", pat(300));
      push(32'h0003_0005);
      pop_check("wrap_rd", {16{8'h11}});

      // ---- reset while in WAIT with three reads queued and an ack in flight
      push(32'd5);
      push(32'd6);
      rd_addr_en  = 1'b1;
      rd_addr     = 32'd7;
      wr_en       = 1'b1;
      wr_addr     = 32'd9;
      wr_data     = pat(400);
      wr_datamask = '0;
      tick();
      rd_addr_en = 1'b0;
      wr_en      = 1'b0;
      check("pre_rst_level", 128'(rq_level), 128'd3);
      reset_n = 1'b0;
      tick();
      check("mid_rst_valid", 128'(rd_valid), 128'd0);
      check("mid_rst_level", 128'(rq_level), 128'd0);
      check("mid_rst_cal",   128'(cal_done), 128'd0);
      tick();
      reset_n = 1'b1;
      seen = 0;
      for (int j = 0; j < 12; j++) begin
         tick();
         if (rd_valid || wr_ack) seen++;
      end
      check("post_rst_quiet", 128'(seen),     128'd0);
      check("post_rst_level", 128'(rq_level), 128'd0);
      check("post_rst_cal",   128'(cal_done), 128'd1);
      push(32'd9);
      pop_check("mem_retained", pat(400));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
